position_tracker: RTL

Upstream stage of `monitor`: turns raw two-channel quadrature sensor lines into a debounced, signed-direction position count and raises the single-cycle `position` pulse that `monitor` consumes to fire `gatilho`. The pulse asserts exactly when the tracked count arrives at a programmable target. The block also exposes the live count, the last step direction and an illegal-transition flag for diagnostics.

---
 rtl/position_tracker.sv | 64 ++++++
 1 files changed

// File: rtl/position_tracker.sv
// position_tracker: debounced quadrature decoder with wrapping count and target-hit pulse
module position_tracker #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enable,
  input  logic             load_target,
  input  logic [WIDTH-1:0] target_in,
  output logic             position,
  output logic [WIDTH-1:0] count,
  output logic             direction,
  output logic             err
);
  logic [1:0] s1, s2, acc, prev, pb, cb, dlt;
  logic [3:0] cnt [2];
  logic [WIDTH-1:0] target, nxt;
  logic fwd, rev, bad;
  // Gray {a,b} to binary phase; the phase difference mod 4 classifies the step
  always_comb begin
    pb  = {prev[1], ^prev};
    cb  = {acc[1], ^acc};
    dlt = cb - pb;
    fwd = dlt == 2'd1;
    rev = dlt == 2'd3;
    bad = dlt == 2'd2;
    nxt = fwd ? count + WIDTH'(1) : count - WIDTH'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      acc       <= '0;
      prev      <= '0;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      target    <= '0;
      count     <= '0;
      position  <= 1'b0;
      direction <= 1'b0;
      err       <= 1'b0;
    end else begin
      s1   <= {enc_a, enc_b};
      s2   <= s1;
      prev <= acc;
      for (int i = 0; i < 2; i++)
        if (s2[i] == acc[i]) cnt[i] <= '0;
        else if (cnt[i] == 4'(DEBOUNCE - 1)) begin
          acc[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 4'd1;
      if (load_target) target <= target_in;
      err      <= bad;
      position <= enable && (fwd || rev) && nxt == target;
      if (enable && (fwd || rev)) begin
        count     <= nxt;
        direction <= fwd;
      end
    end
  end
endmodule
